// File: rtl/sensor_tlm_pkg.sv
// Shared types and constants for the sensor telemetry frame sequencer.
// Frame length grows by one CKSUM byte when SENSOR_TLM_CHECKSUM_EN is defined.
package sensor_tlm_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HDR0,
        HDR1,
        SEQ,
        RADDR,
        RWAIT,
        SEND,
        CKSUM,
        DONE
    } state_t;

    localparam logic [7:0] SYNC0_DEF = 8'hA5;
    localparam logic [7:0] SYNC1_DEF = 8'h5A;

    function automatic int frame_len(input int num_ch);
`ifdef SENSOR_TLM_CHECKSUM_EN
        return 3 * num_ch + 4;
`else
        return 3 * num_ch + 3;
`endif
    endfunction

endpackage

// File: rtl/tlm_period_timer.sv
// Free-running frame period counter: one-cycle tick at PERIOD-1, then wraps to 0.
// Held at 0 while enable is low, so the first tick comes PERIOD cycles after enable rises.
module tlm_period_timer #(
    parameter int PERIOD = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sensor_tlm_seq.sv
// Telemetry frame sequencer: reads the register bank and streams SYNC0 SYNC1 SEQ data [CKSUM]
// over valid/ready; every output is registered, bytes hold until accepted. Macro: SENSOR_TLM_CHECKSUM_EN.
module sensor_tlm_seq
    import sensor_tlm_pkg::*;
#(
    parameter int          NUM_CH = 23,
    parameter int          RD_LAT = 1,
    parameter int          PERIOD = 100000,
    parameter logic [7:0]  SYNC0  = SYNC0_DEF,
    parameter logic [7:0]  SYNC1  = SYNC1_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        start,
    output logic [7:0]  addr,
    input  logic [7:0]  data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        overrun
);

    localparam logic [7:0] LAST_ADDR = 8'(3 * NUM_CH - 1);
    localparam logic [1:0] WAIT_INIT = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    state_t      state, state_n;
    logic [7:0]  addr_n, tx_data_n;
    logic        tx_valid_n, busy_n, overrun_n;
    logic [15:0] frame_cnt_n;
    logic [1:0]  wcnt, wcnt_n;
    logic        tick, capture;
`ifdef SENSOR_TLM_CHECKSUM_EN
    logic [7:0]  cksum, cksum_n;
`endif

    tlm_period_timer #(.PERIOD(PERIOD)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    // Read data is sampled on the last cycle of the address phase.
    assign capture = ((state == RADDR) && (RD_LAT == 0)) ||
                     ((state == RWAIT) && (wcnt == 2'd0));

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        tx_data_n   = tx_data;
        tx_valid_n  = tx_valid;
        busy_n      = busy;
        frame_cnt_n = frame_cnt;
        wcnt_n      = wcnt;
        overrun_n   = overrun | (tick & busy);
`ifdef SENSOR_TLM_CHECKSUM_EN
        cksum_n     = cksum;
`endif
        case (state)
            IDLE: begin
                if (tick || start) begin
                    state_n    = HDR0;
                    tx_data_n  = SYNC0;
                    tx_valid_n = 1'b1;
                    busy_n     = 1'b1;
                end
            end
            HDR0: begin
                if (tx_ready) begin
                    state_n   = HDR1;
                    tx_data_n = SYNC1;
                end
            end
            HDR1: begin
                if (tx_ready) begin
                    state_n   = SEQ;
                    tx_data_n = frame_cnt[7:0];
`ifdef SENSOR_TLM_CHECKSUM_EN
                    cksum_n   = frame_cnt[7:0];
`endif
                end
            end
            SEQ: begin
                if (tx_ready) begin
                    state_n    = RADDR;
                    tx_valid_n = 1'b0;
                end
            end
            RADDR: begin
                if (RD_LAT != 0) begin
                    state_n = RWAIT;
                    wcnt_n  = WAIT_INIT;
                end
            end
            RWAIT: begin
                if (wcnt != 2'd0) begin
                    wcnt_n = wcnt - 2'd1;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (addr == LAST_ADDR) begin
`ifdef SENSOR_TLM_CHECKSUM_EN
                        state_n   = CKSUM;
                        tx_data_n = 8'd0 - cksum;
`else
                        state_n    = DONE;
                        tx_valid_n = 1'b0;
`endif
                    end else begin
                        state_n    = RADDR;
                        addr_n     = addr + 8'd1;
                        tx_valid_n = 1'b0;
                    end
                end
            end
`ifdef SENSOR_TLM_CHECKSUM_EN
            CKSUM: begin
                if (tx_ready) begin
                    state_n    = DONE;
                    tx_valid_n = 1'b0;
                end
            end
`endif
            DONE: begin
                state_n     = IDLE;
                busy_n      = 1'b0;
                addr_n      = 8'd0;
                frame_cnt_n = frame_cnt + 16'd1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (capture) begin
            state_n    = SEND;
            tx_data_n  = data;
            tx_valid_n = 1'b1;
`ifdef SENSOR_TLM_CHECKSUM_EN
            cksum_n    = cksum + data;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr      <= 8'd0;
            tx_data   <= 8'd0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= 16'd0;
            overrun   <= 1'b0;
            wcnt      <= 2'd0;
`ifdef SENSOR_TLM_CHECKSUM_EN
            cksum     <= 8'd0;
`endif
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            tx_data   <= tx_data_n;
            tx_valid  <= tx_valid_n;
            busy      <= busy_n;
            frame_cnt <= frame_cnt_n;
            overrun   <= overrun_n;
            wcnt      <= wcnt_n;
`ifdef SENSOR_TLM_CHECKSUM_EN
            cksum     <= cksum_n;
`endif
        end
    end

endmodule
